// File: rtl/layer_search_best_mv.sv
// layer_search_best_mv
// Walks a (2*RANGE_X) x (2*RANGE_Y) search window in raster order. It takes one
// packed vector of per-partition SADs per position and keeps, for each
// partition, the minimum SAD and the motion vector where it occurred. A one-cycle
// done pulse marks final results for the next-layer refinement search.
//
// Optional build macro: SEARCH_MVCOST_EN
//   When it is defined, each candidate is compared as
//   sat(SAD + LAMBDA*(|mvx|+|mvy|)), and best_sad holds that cost-adjusted value.
//   When it is undefined, raw SADs are compared and LAMBDA is not used.
module layer_search_best_mv #(
    parameter int NUM_PART = 4,
    parameter int SAD_W    = 16,
    parameter int RANGE_X  = 16,
    parameter int RANGE_Y  = 16,
    parameter int MV_W     = 7,
    parameter int LAMBDA   = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                sad_valid,
    input  logic [NUM_PART*SAD_W-1:0]           sad_in,
    output logic                                sad_ready,
    output logic [$clog2(2*RANGE_X)-1:0]        search_column_count,
    output logic [$clog2(2*RANGE_Y)-1:0]        search_row_count,
    output logic [NUM_PART*SAD_W-1:0]           best_sad,
    output logic [NUM_PART*MV_W-1:0]            best_mvx,
    output logic [NUM_PART*MV_W-1:0]            best_mvy,
    output logic                                busy,
    output logic                                done
);

    localparam int CW = $clog2(2*RANGE_X);
    localparam int RW = $clog2(2*RANGE_Y);
    localparam logic [CW-1:0] COL_LAST = CW'(2*RANGE_X-1);
    localparam logic [RW-1:0] ROW_LAST = RW'(2*RANGE_Y-1);
    localparam logic signed [MV_W-1:0] MVX_MIN = MV_W'(-RANGE_X);
    localparam logic signed [MV_W-1:0] MVY_MIN = MV_W'(-RANGE_Y);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                   r_state;
    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic [SAD_W-1:0]         r_best_sad [NUM_PART];
    logic signed [MV_W-1:0]   r_best_mvx [NUM_PART];
    logic signed [MV_W-1:0]   r_best_mvy [NUM_PART];
    logic                     r_sad_ready;
    logic                     r_busy;
    logic                     r_done;

    logic signed [MV_W-1:0]   w_mvx;
    logic signed [MV_W-1:0]   w_mvy;
    logic                     w_last;
    logic [SAD_W-1:0]         w_cand   [NUM_PART];
    logic [NUM_PART-1:0]      w_better;

`ifdef SEARCH_MVCOST_EN
    localparam int ACC_W = SAD_W + MV_W + 33;

    // Magnitude of a signed MV component. The window range keeps -2^(MV_W-1) out of reach.
    function automatic logic [MV_W-1:0] abs_mv(input logic signed [MV_W-1:0] v);
        return v[MV_W-1] ? MV_W'(-v) : MV_W'(v);
    endfunction

    // Adds the MV cost to the SAD and clamps the result to the SAD width.
    function automatic logic [SAD_W-1:0] sat_cost(input logic [SAD_W-1:0] cand,
                                                  input logic [MV_W:0]    mag);
        logic [ACC_W-1:0] acc;
        acc = ACC_W'(cand) + ACC_W'(LAMBDA) * ACC_W'(mag);
        if (acc > ACC_W'({SAD_W{1'b1}})) begin
            return {SAD_W{1'b1}};
        end
        return acc[SAD_W-1:0];
    endfunction
`endif

    // The window origin is at (-RANGE_X, -RANGE_Y), so the MV is the counter
    // value plus that offset.
    assign w_mvx  = MV_W'(r_col) + MVX_MIN;
    assign w_mvy  = MV_W'(r_row) + MVY_MIN;
    assign w_last = (r_col == COL_LAST) && (r_row == ROW_LAST);

    // Per-partition compare value and strict-less-than test (a tie keeps the earlier position)
    always_comb begin
        for (int p = 0; p < NUM_PART; p++) begin
`ifdef SEARCH_MVCOST_EN
            w_cand[p] = sat_cost(sad_in[p*SAD_W +: SAD_W],
                                 {1'b0, abs_mv(w_mvx)} + {1'b0, abs_mv(w_mvy)});
`else
            w_cand[p] = sad_in[p*SAD_W +: SAD_W];
`endif
            w_better[p] = (w_cand[p] < r_best_sad[p]);
        end
    end

    // Search FSM, raster counters and best-candidate registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_sad_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int p = 0; p < NUM_PART; p++) begin
                r_best_sad[p] <= '0;
                r_best_mvx[p] <= '0;
                r_best_mvy[p] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= S_SEARCH;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_sad_ready <= 1'b1;
                        r_busy      <= 1'b1;
                        for (int p = 0; p < NUM_PART; p++) begin
                            r_best_sad[p] <= '1;
                            r_best_mvx[p] <= MVX_MIN;
                            r_best_mvy[p] <= MVY_MIN;
                        end
                    end
                end
                S_SEARCH: begin
                    if (sad_valid) begin
                        for (int p = 0; p < NUM_PART; p++) begin
                            if (w_better[p]) begin
                                r_best_sad[p] <= w_cand[p];
                                r_best_mvx[p] <= w_mvx;
                                r_best_mvy[p] <= w_mvy;
                            end
                        end
                        if (w_last) begin
                            // The counters stay at their maximum values so that the last position remains visible.
                            r_state     <= S_DONE;
                            r_sad_ready <= 1'b0;
                            r_done      <= 1'b1;
                        end else if (r_col == COL_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_sad_ready <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign sad_ready           = r_sad_ready;
    assign busy                = r_busy;
    assign done                = r_done;
    assign search_column_count = r_col;
    assign search_row_count    = r_row;

    for (genvar g = 0; g < NUM_PART; g++) begin : g_pack
        assign best_sad[g*SAD_W +: SAD_W] = r_best_sad[g];
        assign best_mvx[g*MV_W  +: MV_W]  = r_best_mvx[g];
        assign best_mvy[g*MV_W  +: MV_W]  = r_best_mvy[g];
    end

endmodule

// File: tb/tb_layer_search_best_mv.sv
// Directed bench for layer_search_best_mv at default parameters.
module tb_layer_search_best_mv;

    localparam int NP = 4;
    localparam int SW = 16;
    localparam int MW = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              sad_valid;
    logic [NP*SW-1:0]  sad_in;
    logic              sad_ready;
    logic [4:0]        search_column_count;
    logic [4:0]        search_row_count;
    logic [NP*SW-1:0]  best_sad;
    logic [NP*MW-1:0]  best_mvx;
    logic [NP*MW-1:0]  best_mvy;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    layer_search_best_mv #(
        .NUM_PART(4), .SAD_W(16), .RANGE_X(16), .RANGE_Y(16), .MV_W(7), .LAMBDA(4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .sad_valid           (sad_valid),
        .sad_in              (sad_in),
        .sad_ready           (sad_ready),
        .search_column_count (search_column_count),
        .search_row_count    (search_row_count),
        .best_sad            (best_sad),
        .best_mvx            (best_mvx),
        .best_mvy            (best_mvy),
        .busy                (busy),
        .done                (done)
    );

    localparam logic [NP*MW-1:0] MV_MIN4  = {4{7'h70}};            // -16 in every partition
    localparam logic [NP*SW-1:0] SAD_ONES = {4{16'hFFFF}};
`ifdef SEARCH_MVCOST_EN
    localparam logic [NP*SW-1:0] C_SAD = {4{16'h0035}};
    localparam logic [NP*MW-1:0] C_MVX = {4{7'h00}};
    localparam logic [NP*MW-1:0] C_MVY = {4{7'h00}};
    localparam logic [NP*SW-1:0] H_SAD = {16'h0100, 16'h004C, 16'h0100, 16'h0100};
    localparam logic [NP*MW-1:0] H_MVX = {7'h00, 7'h04, 7'h00, 7'h00};
    localparam logic [NP*MW-1:0] H_MVY = {7'h00, 7'h75, 7'h00, 7'h00};
`else
    localparam logic [NP*SW-1:0] C_SAD = {4{16'h0035}};
    localparam logic [NP*MW-1:0] C_MVX = {4{7'h70}};
    localparam logic [NP*MW-1:0] C_MVY = {4{7'h70}};
    localparam logic [NP*SW-1:0] H_SAD = {16'h0100, 16'h0010, 16'h0100, 16'h0100};
    localparam logic [NP*MW-1:0] H_MVX = {7'h70, 7'h04, 7'h70, 7'h70};
    localparam logic [NP*MW-1:0] H_MVY = {7'h70, 7'h75, 7'h70, 7'h70};
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The hot pattern puts 0x0010 on partition 2 at col 20, row 5 (beat 180).
    function automatic logic [NP*SW-1:0] stim(input bit hot, input int beat);
        logic [NP*SW-1:0] v;
        for (int p = 0; p < NP; p++) begin
            if (!hot)                    v[p*SW +: SW] = 16'h0035;
            else if (p == 2 && beat == 180) v[p*SW +: SW] = 16'h0010;
            else                         v[p*SW +: SW] = 16'h0100;
        end
        return v;
    endfunction

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs from the first SEARCH cycle until done. It returns the done latency,
    // the pulse count and the state of the counter tracking.
    task automatic run_search(input bit gaps, input bit hot, input int poke,
                              input bit start_at_done,
                              output int dcyc, output int ndone, output bit pos_ok,
                              output logic sr_at_done, output logic busy_at_done);
        int  cyc;
        int  beat;
        int  ec;
        int  er;
        bit  v;
        pos_ok = 1'b1; ndone = 0; dcyc = -1; cyc = 0; beat = 0;
        sr_at_done = 1'bx; busy_at_done = 1'bx;
        while (ndone == 0 && cyc < 5000) begin
            v = gaps ? (cyc % 2 == 0) : 1'b1;
            sad_valid = v;
            sad_in    = stim(hot, beat);
            if (v && beat == poke) start = 1'b1;
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (v) beat++;
            ec = (beat >= 1024) ? 31 : beat % 32;
            er = (beat >= 1024) ? 31 : beat / 32;
            if (search_column_count !== 5'(ec) || search_row_count !== 5'(er)) pos_ok = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                dcyc = cyc;
                sr_at_done = sad_ready;
                busy_at_done = busy;
            end
        end
        sad_valid = 1'b0;
        start = start_at_done;
        @(negedge clk);
        start = 1'b0;
        if (done !== 1'b0) ndone++;
    endtask

    initial begin
        int   dc;
        int   nd;
        bit   pok;
        logic srd;
        logic bsd;

        rst_n = 1'b0; start = 1'b0; sad_valid = 1'b0; sad_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_col", search_column_count, 0);
        chk("rst_row", search_row_count, 0);
        chk("rst_sad", best_sad, 0);
        chk("rst_mvx", best_mvx, 0);
        chk("rst_mvy", best_mvy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", sad_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: constant SAD with a continuous valid.
        kick();
        chk("t1_entry_ready", sad_ready, 1);
        chk("t1_entry_busy", busy, 1);
        chk("t1_entry_col", search_column_count, 0);
        chk("t1_entry_row", search_row_count, 0);
        chk("t1_entry_sad", best_sad, SAD_ONES);
        chk("t1_entry_mvx", best_mvx, MV_MIN4);
        chk("t1_entry_mvy", best_mvy, MV_MIN4);
        run_search(1'b0, 1'b0, -1, 1'b0, dc, nd, pok, srd, bsd);
        chk("t1_latency", dc, 1024);
        chk("t1_ndone", nd, 1);
        chk("t1_pos", pok, 1);
        chk("t1_ready_in_done", srd, 0);
        chk("t1_busy_in_done", bsd, 1);
        chk("t1_busy_idle", busy, 0);
        chk("t1_sad", best_sad, C_SAD);
        chk("t1_mvx", best_mvx, C_MVX);
        chk("t1_mvy", best_mvy, C_MVY);
        chk("t1_col", search_column_count, 31);
        chk("t1_row", search_row_count, 31);
        repeat (3) @(negedge clk);
        chk("t1_hold_sad", best_sad, C_SAD);
        chk("t1_hold_mvx", best_mvx, C_MVX);

        // Test 2: a single hot spot on partition 2.
        kick();
        run_search(1'b0, 1'b1, -1, 1'b0, dc, nd, pok, srd, bsd);
        chk("t2_latency", dc, 1024);
        chk("t2_sad", best_sad, H_SAD);
        chk("t2_mvx", best_mvx, H_MVX);
        chk("t2_mvy", best_mvy, H_MVY);

        // Test 3: the same hot spot with valid asserted only every other cycle.
        kick();
        run_search(1'b1, 1'b1, -1, 1'b0, dc, nd, pok, srd, bsd);
        chk("t3_latency", dc, 2047);
        chk("t3_ndone", nd, 1);
        chk("t3_pos_frozen", pok, 1);
        chk("t3_sad", best_sad, H_SAD);
        chk("t3_mvx", best_mvx, H_MVX);
        chk("t3_mvy", best_mvy, H_MVY);

        // Test 4: start is pulsed at beat 100 and again during the DONE cycle.
        kick();
        run_search(1'b0, 1'b0, 100, 1'b1, dc, nd, pok, srd, bsd);
        chk("t4_latency", dc, 1024);
        chk("t4_ndone", nd, 1);
        chk("t4_pos", pok, 1);
        @(negedge clk);
        chk("t4_no_restart_busy", busy, 0);
        chk("t4_no_restart_ready", sad_ready, 0);

        // Test 5: reset at beat 500, followed by a clean hot-spot search.
        kick();
        for (int i = 0; i < 500; i++) begin
            sad_valid = 1'b1;
            sad_in = stim(1'b0, i);
            @(negedge clk);
        end
        chk("t5_mid_col", search_column_count, 500 % 32);
        chk("t5_mid_row", search_row_count, 500 / 32);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sad_valid = 1'b0;
        chk("t5_rst_col", search_column_count, 0);
        chk("t5_rst_row", search_row_count, 0);
        chk("t5_rst_sad", best_sad, 0);
        chk("t5_rst_mvx", best_mvx, 0);
        chk("t5_rst_mvy", best_mvy, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", sad_ready, 0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            sad_valid = 1'b1;
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) nd++;
        end
        sad_valid = 1'b0;
        chk("t5_idle_quiet", nd, 0);
        kick();
        run_search(1'b0, 1'b1, -1, 1'b0, dc, nd, pok, srd, bsd);
        chk("t5_latency", dc, 1024);
        chk("t5_ndone", nd, 1);
        chk("t5_pos", pok, 1);
        chk("t5_sad", best_sad, H_SAD);
        chk("t5_mvx", best_mvx, H_MVX);
        chk("t5_mvy", best_mvy, H_MVY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_search_best_mv.md
Name: layer_search_best_mv

Overview:
- Parametrised successor to the fixed-size basic-layer search control.
- Walks a configurable search window in raster order and publishes the current position on row/column counters.
- Accepts one packed vector of per-partition SADs per position from the PE array and tracks, per partition, the minimum SAD and its motion vector.
- Sits between the SAD PE array and the next-layer (refinement) search; reports best SAD/MV per partition with a done pulse.

Parameters:
- NUM_PART, 4, number of partitions whose SADs arrive in parallel
- SAD_W, 16, bits per partition SAD
- RANGE_X, 16, horizontal range; MVx spans -RANGE_X..RANGE_X-1
- RANGE_Y, 16, vertical range; MVy spans -RANGE_Y..RANGE_Y-1
- MV_W, 7, signed two's-complement MV component width; must hold ±max(RANGE_X,RANGE_Y)
- LAMBDA, 4, MV cost weight; used only with SEARCH_MVCOST_EN

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a new window search; honoured only in IDLE
- sad_valid  in  1  sad_in holds SADs for the current position
- sad_in  in  NUM_PART*SAD_W  partition p at bits [p*SAD_W +: SAD_W]
- sad_ready  out  1  high only in SEARCH
- search_column_count  out  clog2(2*RANGE_X)  current column, 0..2*RANGE_X-1
- search_row_count  out  clog2(2*RANGE_Y)  current row, 0..2*RANGE_Y-1
- best_sad  out  NUM_PART*SAD_W  running/final minimum per partition
- best_mvx  out  NUM_PART*MV_W  MVx of best_sad per partition
- best_mvy  out  NUM_PART*MV_W  MVy of best_sad per partition
- busy  out  1  high in SEARCH and DONE
- done  out  1  one-cycle pulse, results final

Behaviour:
- Reset (rst_n=0 at a clk edge) forces IDLE and clears all outputs to 0: counters, best_sad, best_mvx/mvy, busy, done, sad_ready. Reset mid-search abandons the search; no done pulse is produced.
- FSM states: IDLE, SEARCH, DONE.
- IDLE, start=1: go to SEARCH next cycle. Counters load 0. Every best_sad loads all-ones. Every best_mv loads (-RANGE_X,-RANGE_Y).
- SEARCH: sad_ready=1. A beat is accepted when sad_valid=1. Gaps with sad_valid=0 hold all state.
- Per accepted beat, for each partition p: cand = sad_in[p]. If cand < best_sad[p] (strict), then best_sad[p] <= cand, best_mvx[p] <= col - RANGE_X, best_mvy[p] <= row - RANGE_Y. Updates are visible the cycle after acceptance.
- Tie rule: ties keep the earlier (raster-first) position.
- Counter advance on an accepted beat: column increments. At 2*RANGE_X-1 the column wraps to 0 and the row increments.
- Last position is col=2*RANGE_X-1, row=2*RANGE_Y-1. Accepting it moves to DONE and leaves both counters at their maximum values.
- Total beats per search = 4*RANGE_X*RANGE_Y (1024 at defaults).
- DONE: lasts exactly one cycle; done=1, sad_ready=0. Then return to IDLE.
- best_* hold their final values in IDLE until the next start.
- start in SEARCH or DONE is ignored.
- start in the same cycle as a DONE-to-IDLE transition is ignored; start must be sampled in IDLE.
- Arithmetic: unsigned SAD compare at SAD_W. MVs are produced as signed values sign-extended to MV_W.

Optional Feature:
- Macro: SEARCH_MVCOST_EN.
- Defined: compare value = min(cand + LAMBDA*(|mvx|+|mvy|), 2^SAD_W-1), i.e. saturating.
  - best_sad stores this cost-adjusted value.
  - At start, best_sad and best_mv are preloaded by the same rule as undefined; only the compare value changes.
- Undefined: raw SAD compare; LAMBDA unused; no extra logic.

Test Plan:
- Defaults, constant sad_in=0x0035 every partition, sad_valid=1 continuously -> done exactly 1024 cycles after the SEARCH entry cycle; all best_sad=0x0035; all MV=(-16,-16); counters read col 31, row 31.
- sad_in=0x0100 everywhere except partition 2 = 0x0010 at col 20, row 5 -> partition 2 MV=(4,-11), best_sad=0x0010; others (-16,-16) with 0x0100.
- Same stimulus with sad_valid deasserted every other cycle -> identical results; done at 2047-2048 cycles; counters frozen during gaps.
- start pulsed at beat 100 of a search -> ignored; counters continue; single done pulse at the normal time.
- rst_n=0 for 1 cycle at beat 500 -> next cycle all outputs 0, state IDLE, no done; a following start runs a full clean 1024-beat search.
- With SEARCH_MVCOST_EN defined, LAMBDA=4, constant sad_in=0x0035 -> all MV=(0,0), best_sad=0x0035. Without the macro -> (-16,-16).
